timer_bridge_intc: RTL and testbench
====================================

Name: timer_bridge_intc

Overview:
- System bridge between the CPU MEM-stage bus and two COCO timers (register file CTRL/PRESET/COUNT at word offsets 0/1/2).
- Decodes CPU addresses into per-timer write strobes and muxes timer read data back.
- Contains an interrupt controller that edge-latches device IntReq lines plus external lines into sticky pending bits, masks them, and drives HWInt to CP0.
- Sits between the MEM stage and the timer instances.

Parameters:
- T0_BASE, 32'h0000_7F00, base of timer0 window (16 bytes)
- T1_BASE, 32'h0000_7F10, base of timer1 window (16 bytes)
- IC_BASE, 32'h0000_7F20, base of interrupt-controller window (16 bytes)
- NIRQ, 6, number of interrupt lines (bit0 = timer0, bit1 = timer1, bits 5:2 external)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- PrAddr  in  32  CPU byte address; bits [1:0] ignored
- PrWD  in  32  CPU write data
- PrWE  in  1  CPU write enable, one cycle per store
- PrRD  out  32  read data, combinational, same cycle as PrAddr
- PrErr  out  1  combinational; high when PrAddr hits no window
- DEV_Addr  out  2  PrAddr[3:2] forwarded to timers
- DEV_WD  out  32  PrWD forwarded
- DEV_WE  out  2  per-timer write strobe
- DEV_RD0  in  32  timer0 Dout
- DEV_RD1  in  32  timer1 Dout
- IRQ  in  NIRQ  raw requests: {ext[3:0], timer1 IntReq, timer0 IntReq}
- HWInt  out  NIRQ  masked pending, to CP0 Cause.IP

Behaviour:
- Reset (asynchronous, active-high): MASK = 0, PEND = 0, irq_q = 0.
  - Outputs: HWInt = 0; DEV_WE = 0 unless PrWE is high.
- Decode is combinational on PrAddr[31:4] against the three bases.
  - DEV_WE[i] = PrWE & hit_i.
  - PrRD = DEV_RDi on a timer hit, the IC register on an IC hit, 0 otherwise.
- Unmapped access: PrErr = 1, writes are dropped, PrRD = 0.
- IC registers (word offset PrAddr[3:2]):
  - 0 MASK: rw; bits [NIRQ-1:0] are writable; upper bits read 0.
  - 1 PEND: read returns the pending bits; a write is write-1-to-clear.
  - 2 ID: read-only; index of the lowest set bit of PEND&MASK, or 32'hFFFF_FFFF if that value is 0. Writes are ignored.
  - 3: reserved; reads 0, writes are ignored.
- Edge detect:
  - irq_q <= IRQ each cycle.
  - rise = IRQ & ~irq_q.
  - PEND <= (PEND & ~clr) | rise, where clr = PrWD[NIRQ-1:0] when a PEND write is decoded, else 0.
- Simultaneous rise and clear on the same bit: set wins, so the bit stays 1.
- A level held high does not re-set PEND after it is cleared; the line must fall and rise again.
  - This covers mode-0 timers holding IntReq.
  - Mode-1 one-cycle pulses are captured.
- HWInt = PEND & MASK, driven only from flops.
  - Latency: IRQ rising at cycle n gives HWInt high after edge n.
  - A MASK or PEND write takes effect after its edge.
- Masked-off lines still latch into PEND; unmasking later raises HWInt immediately.
- Timers are not reset by this block; reset fans out separately.

Decomposition:
- Package bridge_pkg:
  - Base address constants and IC offsets (OFF_MASK=2'd0, OFF_PEND=2'd1, OFF_ID=2'd2).
  - IRQ bit indices (IRQ_T0=0, IRQ_T1=1).
  - ID_NONE = 32'hFFFF_FFFF.
- Sub-module intc_core holds the MASK/PEND/irq_q flops and the priority encoder. The top level is decode and muxing only.

Test Plan:
- Store 0x7F00 <- 32'h8, then 0x7F04 <- 15 → DEV_WE = 2'b01 with DEV_Addr = 0 then 1; DEV_WD = 8 then 15; DEV_WE[1] never asserts.
- Load 0x7F18 with DEV_RD1 = 32'h1234 → PrRD = 32'h1234 in the same cycle, PrErr = 0. Load 0x8000 → PrRD = 0, PrErr = 1; a store there raises no DEV_WE.
- MASK <- 6'b000011, one-cycle pulse on IRQ[0] → PEND = 1 and HWInt = 6'b000001 after the edge; ID reads 0. PEND <- 1 → HWInt = 0 the next cycle.
- IRQ[1] held high for 20 cycles with PEND cleared at cycle 5 → PEND[1] stays 0 after the clear. IRQ[1] low then high → PEND[1] = 1 again.
- Rise on IRQ[0] in the same cycle as PEND <- 1 → PEND[0] = 1 (set wins).
- MASK = 0, pulses on IRQ[5] and IRQ[2] → HWInt = 0, PEND = 6'b100100. MASK <- 6'b100000 → HWInt = 6'b100000, ID = 5. Assert reset mid-sequence → MASK, PEND and HWInt go to 0 immediately without waiting for clk.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared constants for the timer bridge and its interrupt controller.
//   - Default base addresses of the timer0, timer1 and interrupt-controller
//     windows. Each window is 16 bytes.
//   - Word offsets of the interrupt-controller registers.
//   - Interrupt line count and the line indices used by the timers.
//   - lowest_id(): priority encoder that returns the index of the lowest set
//     bit, or ID_NONE when no bit is set.
package bridge_pkg;

   localparam logic [31:0] T0_BASE_ADDR = 32'h0000_7F00;
   localparam logic [31:0] T1_BASE_ADDR = 32'h0000_7F10;
   localparam logic [31:0] IC_BASE_ADDR = 32'h0000_7F20;

   localparam int NIRQ = 6;

   localparam logic [1:0] OFF_MASK = 2'd0;
   localparam logic [1:0] OFF_PEND = 2'd1;
   localparam logic [1:0] OFF_ID   = 2'd2;

   localparam int IRQ_T0 = 0;
   localparam int IRQ_T1 = 1;

   localparam logic [31:0] ID_NONE = 32'hFFFF_FFFF;

   // The scan runs from the top bit down, so the last hit is the lowest
   // set bit. That bit has the highest priority.
   function automatic logic [31:0] lowest_id(input logic [NIRQ-1:0] v);
      logic [31:0] id;
      id = ID_NONE;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (v[i]) id = 32'(i);
      end
      return id;
   endfunction

endpackage

// File: rtl/intc_core.sv
// Interrupt controller core.
// Edge-detects the raw request lines into sticky pending bits, masks them,
// and serves the MASK/PEND/ID register reads.
// Ports:
//   clk, reset - clock; asynchronous active-high reset
//   wr_en      - register write strobe; the bus has already decoded an IC hit
//   off        - register word offset (PrAddr[3:2])
//   wd         - write data
//   irq        - raw request lines
//   rd         - read data for the register selected by off (combinational)
//   hwint      - PEND & MASK. Both operands come straight from flops.
module intc_core
   import bridge_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  logic [1:0]      off,
   input  logic [31:0]     wd,
   input  logic [NIRQ-1:0] irq,
   output logic [31:0]     rd,
   output logic [NIRQ-1:0] hwint
);

   logic [NIRQ-1:0] mask_q;
   logic [NIRQ-1:0] pend_q;
   logic [NIRQ-1:0] irq_q;
   logic [NIRQ-1:0] rise;
   logic [NIRQ-1:0] clr;
   logic [NIRQ-1:0] active;

   assign rise   = irq & ~irq_q;
   assign clr    = (wr_en && off == OFF_PEND) ? wd[NIRQ-1:0] : '0;
   assign active = pend_q & mask_q;
   assign hwint  = active;

   // OR-ing in rise after the clear means a new edge wins over a
   // write-1-to-clear in the same cycle. Because irq_q tracks the line, a
   // level that is held high rises only once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q <= '0;
         pend_q <= '0;
         irq_q  <= '0;
      end else begin
         irq_q  <= irq;
         pend_q <= (pend_q & ~clr) | rise;
         if (wr_en && off == OFF_MASK) mask_q <= wd[NIRQ-1:0];
      end
   end

   always_comb begin
      rd = '0;
      case (off)
         OFF_MASK: rd[NIRQ-1:0] = mask_q;
         OFF_PEND: rd[NIRQ-1:0] = pend_q;
         OFF_ID:   rd = lowest_id(active);
         default:  rd = '0;
      endcase
   end

endmodule

// File: rtl/timer_bridge_intc.sv
// System bridge between the CPU MEM-stage bus and two timers, with an
// integrated interrupt controller.
// Ports:
//   clk, reset         - clock; asynchronous active-high reset
//   PrAddr/PrWD/PrWE   - CPU byte address, write data and write enable
//   PrRD               - read data, combinational from PrAddr
//   PrErr              - high when PrAddr hits no window
//   DEV_Addr/DEV_WD    - word offset and write data forwarded to both timers
//   DEV_WE             - per-timer write strobe
//   DEV_RD0/DEV_RD1    - timer read data
//   IRQ                - raw requests {ext[3:0], timer1, timer0}
//   HWInt              - masked pending interrupts to CP0
// This level only decodes and muxes; all state lives in intc_core.
module timer_bridge_intc
   import bridge_pkg::*;
#(
   parameter logic [31:0] T0_BASE = T0_BASE_ADDR,
   parameter logic [31:0] T1_BASE = T1_BASE_ADDR,
   parameter logic [31:0] IC_BASE = IC_BASE_ADDR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     PrAddr,
   input  logic [31:0]     PrWD,
   input  logic            PrWE,
   output logic [31:0]     PrRD,
   output logic            PrErr,
   output logic [1:0]      DEV_Addr,
   output logic [31:0]     DEV_WD,
   output logic [1:0]      DEV_WE,
   input  logic [31:0]     DEV_RD0,
   input  logic [31:0]     DEV_RD1,
   input  logic [NIRQ-1:0] IRQ,
   output logic [NIRQ-1:0] HWInt
);

   logic        hit_t0;
   logic        hit_t1;
   logic        hit_ic;
   logic [31:0] ic_rd;

   // Each window is 16 bytes, so the match uses the address bits above the
   // window offset.
   assign hit_t0 = (PrAddr[31:4] == T0_BASE[31:4]);
   assign hit_t1 = (PrAddr[31:4] == T1_BASE[31:4]);
   assign hit_ic = (PrAddr[31:4] == IC_BASE[31:4]);

   assign PrErr    = ~(hit_t0 | hit_t1 | hit_ic);
   assign DEV_Addr = PrAddr[3:2];
   assign DEV_WD   = PrWD;
   assign DEV_WE   = {PrWE & hit_t1, PrWE & hit_t0};

   always_comb begin
      PrRD = '0;
      if (hit_t0)      PrRD = DEV_RD0;
      else if (hit_t1) PrRD = DEV_RD1;
      else if (hit_ic) PrRD = ic_rd;
   end

   intc_core u_intc (
      .clk   (clk),
      .reset (reset),
      .wr_en (PrWE & hit_ic),
      .off   (PrAddr[3:2]),
      .wd    (PrWD),
      .irq   (IRQ),
      .rd    (ic_rd),
      .hwint (HWInt)
   );

endmodule

// File: tb/tb_timer_bridge_intc.sv
// Directed testbench for timer_bridge_intc.
// Inputs are changed 1 ns after a rising edge. Outputs are sampled before
// the next rising edge.
module tb_timer_bridge_intc;
   import bridge_pkg::*;

   // ---------------- clock / reset ----------------
   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [31:0]     PrAddr = '0;
   logic [31:0]     PrWD = '0;
   logic            PrWE = 1'b0;
   logic [31:0]     PrRD;
   logic            PrErr;
   logic [1:0]      DEV_Addr;
   logic [31:0]     DEV_WD;
   logic [1:0]      DEV_WE;
   logic [31:0]     DEV_RD0 = 32'hAAAA_0000;
   logic [31:0]     DEV_RD1 = 32'h0000_1234;
   logic [NIRQ-1:0] IRQ = '0;
   logic [NIRQ-1:0] HWInt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   timer_bridge_intc dut (
      .clk      (clk),
      .reset    (reset),
      .PrAddr   (PrAddr),
      .PrWD     (PrWD),
      .PrWE     (PrWE),
      .PrRD     (PrRD),
      .PrErr    (PrErr),
      .DEV_Addr (DEV_Addr),
      .DEV_WD   (DEV_WD),
      .DEV_WE   (DEV_WE),
      .DEV_RD0  (DEV_RD0),
      .DEV_RD1  (DEV_RD1),
      .IRQ      (IRQ),
      .HWInt    (HWInt)
   );

   // ---------------- driver / check tasks ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one store for one cycle, then clears the write enable.
   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      PrAddr = addr;
      PrWD   = data;
      PrWE   = 1'b1;
      step();
      PrWE   = 1'b0;
   endtask

   task automatic ic_read(input string tag, input logic [1:0] off, input logic [31:0] exp);
      PrWE   = 1'b0;
      PrAddr = IC_BASE_ADDR + {28'd0, off, 2'b00};
      #1;
      chk(tag, PrRD, exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset state
      step();
      step();
      chk("rst_hwint", 32'(HWInt), 32'h0);
      chk("rst_we", 32'(DEV_WE), 32'h0);
      ic_read("rst_mask", OFF_MASK, 32'h0);
      ic_read("rst_pend", OFF_PEND, 32'h0);
      ic_read("rst_id", OFF_ID, ID_NONE);
      reset = 1'b0;
      step();

      // Timer0 stores
      PrAddr = 32'h7F00; PrWD = 32'h8; PrWE = 1'b1; #1;
      chk("st0_we", 32'(DEV_WE), 32'h1);
      chk("st0_addr", 32'(DEV_Addr), 32'h0);
      chk("st0_wd", DEV_WD, 32'h8);
      step();
      PrAddr = 32'h7F04; PrWD = 32'd15; #1;
      chk("st1_we", 32'(DEV_WE), 32'h1);
      chk("st1_addr", 32'(DEV_Addr), 32'h1);
      chk("st1_wd", DEV_WD, 32'd15);
      step();
      PrWE = 1'b0;

      // Timer reads and the unmapped window
      PrAddr = 32'h7F18; #1;
      chk("rd_t1", PrRD, 32'h1234);
      chk("rd_t1_err", 32'(PrErr), 32'h0);
      PrAddr = 32'h7F08; #1;
      chk("rd_t0", PrRD, 32'hAAAA_0000);
      PrAddr = 32'h8000; #1;
      chk("unmap_rd", PrRD, 32'h0);
      chk("unmap_err", 32'(PrErr), 32'h1);
      PrWE = 1'b1; #1;
      chk("unmap_we", 32'(DEV_WE), 32'h0);
      step();
      PrWE = 1'b0;
      PrAddr = 32'h7F2C; #1;
      chk("ic_err", 32'(PrErr), 32'h0);
      chk("ic_rsvd", PrRD, 32'h0);

      // Only the writable MASK bits stick
      bus_write(IC_BASE_ADDR, 32'hFFFF_FFFF);
      ic_read("mask_wide", OFF_MASK, 32'h3F);
      bus_write(IC_BASE_ADDR, 32'h3);
      ic_read("mask_3", OFF_MASK, 32'h3);

      // One-cycle pulse on IRQ[0]
      IRQ[IRQ_T0] = 1'b1;
      step();
      IRQ[IRQ_T0] = 1'b0;
      chk("pulse_hwint", 32'(HWInt), 32'h1);
      ic_read("pulse_pend", OFF_PEND, 32'h1);
      ic_read("pulse_id", OFF_ID, 32'h0);
      bus_write(IC_BASE_ADDR + 32'h8, 32'h7);  // ID is read-only
      ic_read("id_ro", OFF_ID, 32'h0);
      bus_write(IC_BASE_ADDR + 32'h4, 32'h1);
      chk("clr_hwint", 32'(HWInt), 32'h0);
      ic_read("clr_id", OFF_ID, ID_NONE);

      // A held level on IRQ[1] is cleared once and stays clear
      IRQ[IRQ_T1] = 1'b1;
      step();
      ic_read("lvl_set", OFF_PEND, 32'h2);
      chk("lvl_hwint", 32'(HWInt), 32'h2);
      step(); step(); step();
      bus_write(IC_BASE_ADDR + 32'h4, 32'h2);
      ic_read("lvl_clr", OFF_PEND, 32'h0);
      for (int i = 0; i < 14; i++) step();
      ic_read("lvl_stay", OFF_PEND, 32'h0);
      chk("lvl_hw0", 32'(HWInt), 32'h0);
      IRQ[IRQ_T1] = 1'b0;
      step();
      IRQ[IRQ_T1] = 1'b1;
      step();
      ic_read("lvl_rerise", OFF_PEND, 32'h2);
      IRQ[IRQ_T1] = 1'b0;
      bus_write(IC_BASE_ADDR + 32'h4, 32'h2);
      ic_read("lvl_done", OFF_PEND, 32'h0);

      // A rise and a clear of the same bit in one cycle: the set wins
      IRQ[IRQ_T0] = 1'b1;
      step();
      IRQ[IRQ_T0] = 1'b0;
      step();
      ic_read("sw_pre", OFF_PEND, 32'h1);
      IRQ[IRQ_T0] = 1'b1;
      bus_write(IC_BASE_ADDR + 32'h4, 32'h1);
      IRQ[IRQ_T0] = 1'b0;
      ic_read("set_wins", OFF_PEND, 32'h1);
      bus_write(IC_BASE_ADDR + 32'h4, 32'h3F);
      ic_read("sw_clr", OFF_PEND, 32'h0);

      // Masked lines still latch; unmasking raises HWInt immediately
      bus_write(IC_BASE_ADDR, 32'h0);
      IRQ = 6'b100100;
      step();
      IRQ = '0;
      step();
      chk("mskd_hwint", 32'(HWInt), 32'h0);
      ic_read("mskd_pend", OFF_PEND, 32'h24);
      ic_read("mskd_id", OFF_ID, ID_NONE);
      bus_write(IC_BASE_ADDR, 32'h20);
      chk("unmsk_hwint", 32'(HWInt), 32'h20);
      ic_read("unmsk_id", OFF_ID, 32'd5);

      // Reset between edges clears state without a clock
      #2;
      reset = 1'b1;
      #1;
      chk("arst_hwint", 32'(HWInt), 32'h0);
      ic_read("arst_mask", OFF_MASK, 32'h0);
      ic_read("arst_pend", OFF_PEND, 32'h0);
      step();
      reset = 1'b0;
      step();
      chk("post_hwint", 32'(HWInt), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // DEV_WE[1] is never wanted: no store in this run targets timer1
   always @(negedge clk) begin
      if (!reset && DEV_WE[1]) chk("we1_never", 32'(DEV_WE), 32'h1);
   end

endmodule
